sar_adc_sequencer: RTL and testbench

Multi-channel conversion scheduler for the SAR ADC. It arbitrates round-robin among N_CH requesters, drives the analog channel mux select, and runs the ADC's sample/hold/convert sequence through `input_hold_digital`. It captures the quantized result on end-of-conversion and returns it with its channel tag. It sits between the requesting digital logic and the `sar_adc` instance, in the same clock domain as the SAR register's clock.

---
 rtl/sar_adc_sequencer.sv | 158 +++++++++++++++
 tb/tb_sar_adc_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_sequencer.sv
// Round-robin conversion scheduler for the SAR ADC: grants one requester, runs sample/convert, returns the tagged result.
// Optional conversion watchdog enabled by defining SAR_SEQ_TIMEOUT_EN.
module sar_adc_sequencer #(
  parameter int N_BITS         = 10,
  parameter int N_CH           = 4,
  parameter int SAMPLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   ack,
  output logic [CH_W-1:0]   ch_sel,
  output logic              adc_hold,
  input  logic              adc_eoc,
  input  logic [N_BITS-1:0] adc_result,
  output logic [N_BITS-1:0] result_data,
  output logic [CH_W-1:0]   result_ch,
  output logic              result_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_e;

  state_e              state_q;
  logic [CH_W-1:0]     rr_ptr_q;
  logic [CH_W-1:0]     ch_sel_q;
  logic [SMP_W-1:0]    smp_cnt_q;
  logic [N_CH-1:0]     ack_q;
  logic                adc_hold_q;
  logic [N_BITS-1:0]   result_data_q;
  logic [CH_W-1:0]     result_ch_q;
  logic                result_valid_q;
  logic                busy_q;
  logic [CH_W-1:0]     grant_d;
  logic [CH_W-1:0]     rr_ptr_d;

  // First requesting channel at or after the pointer, searching upward with wrap.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] r,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      if (!found && (|(r & (N_CH'(1) << idx)))) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    grant_d  = rr_pick(req, rr_ptr_q);
    rr_ptr_d = (grant_d == CH_W'(N_CH - 1)) ? '0 : grant_d + 1'b1;
  end

`ifdef SAR_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      ch_sel_q       <= '0;
      smp_cnt_q      <= '0;
      ack_q          <= '0;
      adc_hold_q     <= 1'b0;
      result_data_q  <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SAR_SEQ_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      tmo_err_q      <= 1'b0;
`endif
    end else begin
      ack_q          <= '0;
      result_valid_q <= 1'b0;
`ifdef SAR_SEQ_TIMEOUT_EN
      tmo_err_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req) begin
            ch_sel_q   <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            smp_cnt_q  <= '0;
            adc_hold_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (smp_cnt_q == SMP_W'(SAMPLE_CYCLES - 1)) begin
            adc_hold_q <= 1'b1;
`ifdef SAR_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
            state_q    <= CONVERT;
          end else begin
            smp_cnt_q <= smp_cnt_q + 1'b1;
          end
        end
        CONVERT: begin
          // eoc is checked first so it wins over a same-cycle timeout.
          if (adc_eoc) begin
            result_data_q  <= adc_result;
            result_ch_q    <= ch_sel_q;
            result_valid_q <= 1'b1;
            ack_q          <= N_CH'(1) << ch_sel_q;
            adc_hold_q     <= 1'b0;
            state_q        <= DONE;
          end
`ifdef SAR_SEQ_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_err_q  <= 1'b1;
            ack_q      <= N_CH'(1) << ch_sel_q;
            adc_hold_q <= 1'b0;
            state_q    <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack          = ack_q;
  assign ch_sel       = ch_sel_q;
  assign adc_hold     = adc_hold_q;
  assign result_data  = result_data_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
`ifdef SAR_SEQ_TIMEOUT_EN
  assign timeout_err  = tmo_err_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Directed and randomized bench for sar_adc_sequencer with a transaction-level reference model.
module tb_sar_adc_sequencer;

  localparam int NB   = 10;
  localparam int N_CH = 4;
  localparam int S    = 4;
  localparam int TMO  = 64;
  localparam int CH_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N_CH-1:0]   req = '0;
  logic [N_CH-1:0]   ack;
  logic [CH_W-1:0]   ch_sel;
  logic              adc_hold;
  logic              adc_eoc = 1'b0;
  logic [NB-1:0]     adc_result = '0;
  logic [NB-1:0]     result_data;
  logic [CH_W-1:0]   result_ch;
  logic              result_valid;
  logic              busy;
  logic              timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int rr       = 0;

  sar_adc_sequencer #(.N_BITS(NB), .N_CH(N_CH), .SAMPLE_CYCLES(S), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .ch_sel(ch_sel), .adc_hold(adc_hold),
    .adc_eoc(adc_eoc), .adc_result(adc_result), .result_data(result_data), .result_ch(result_ch),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first set bit at or after p, upward with wrap.
  function automatic int pick(input logic [N_CH-1:0] r, input int p);
    for (int i = 0; i < N_CH; i++)
      if (r[(p + i) % N_CH]) return (p + i) % N_CH;
    return -1;
  endfunction

  // One full conversion, starting in IDLE with req already presented.
  task automatic conv(input int k, input logic [NB-1:0] val, input bit early, input bit drop, input bit clr);
    int ch, lat, lo, hi;
    bit stable, tmo;
    ch = pick(req, rr);
    rr = (ch + 1) % N_CH;
    check("idle_busy", busy, 0);
    adc_eoc = early;
    lat = 1; lo = 0; hi = 0; stable = 1'b1; tmo = 1'b0;
    tick();
    check("grant_ch", ch_sel, ch);
    for (int c = 0; c < S + k + 8 && !result_valid; c++) begin
      lat++;
      if (adc_hold) hi++; else lo++;
      if (ch_sel != CH_W'(ch)) stable = 1'b0;
      if (timeout_err) tmo = 1'b1;
      if (drop && adc_hold) req[ch] = 1'b0;
      if (adc_hold && hi == k) begin
        adc_eoc = 1'b1;
        adc_result = val;
      end else begin
        adc_eoc = early && !adc_hold;
        adc_result = NB'($urandom);
      end
      tick();
    end
    check("result_valid", result_valid, 1);
    check("latency", lat, 1 + S + k);
    check("hold_low_cycles", lo, S);
    check("hold_high_cycles", hi, k);
    check("ch_sel_stable", stable, 1);
    check("no_timeout_err", tmo | timeout_err, 0);
    check("result_data", result_data, val);
    check("result_ch", result_ch, ch);
    check("ack", ack, 1 << ch);
    check("done_hold", adc_hold, 0);
    check("done_busy", busy, 1);
    adc_eoc = 1'b0;
    if (clr) req[ch] = 1'b0;
    tick();
    check("post_valid", result_valid, 0);
    check("post_ack", ack, 0);
    check("post_busy", busy, 0);
    check("post_data_hold", result_data, val);
  endtask

  initial begin
    logic [N_CH-1:0] pend;
    logic [NB-1:0]   prev;
    int              ch, cnt;

    // Reset state
    tick();
    check("rst_ack", ack, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_hold", adc_hold, 0);
    check("rst_data", result_data, 0);
    check("rst_rch", result_ch, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout_err, 0);
    #2 reset = 1'b1;
    tick();

    // Round-robin with all requests held: expect 0,1,2,3,0
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check("rr_order", pick(req, rr), i % N_CH);
      conv(2 + i, NB'(10'h100 + i), 1'b0, 1'b0, 1'b0);
    end
    req = '0;

    // Single request, eoc after 11 convert cycles
    req = 4'b0001;
    conv(11, 10'h2A5, 1'b0, 1'b0, 1'b1);

    // Stale eoc while idle must not produce a result
    adc_eoc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stale_valid", result_valid, 0);
      check("stale_busy", busy, 0);
    end
    adc_eoc = 1'b0;

    // Early eoc through SAMPLE: captured on first CONVERT cycle, or not at all until its time
    req = 4'b0010;
    conv(1, 10'h155, 1'b1, 1'b0, 1'b1);
    req = 4'b0001;
    conv(3, 10'h0F0, 1'b1, 1'b0, 1'b1);

    // Request withdrawn during CONVERT
    req = 4'b0100;
    conv(5, 10'h3C3, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with pending requesters
    pend = '0;
    for (int i = 0; i < 24; i++) begin
      req = pend | N_CH'($urandom_range(0, (1 << N_CH) - 1));
      if (req == '0) req[$urandom_range(0, N_CH - 1)] = 1'b1;
      conv($urandom_range(1, 20), NB'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      pend = req;
    end
    req = '0;

`ifdef SAR_SEQ_TIMEOUT_EN
    // eoc never arrives: watchdog aborts after TMO convert cycles
    req = 4'b0010;
    ch = pick(req, rr);
    rr = (ch + 1) % N_CH;
    prev = result_data;
    tick();
    cnt = 0;
    for (int c = 0; c < S + TMO + 20 && !timeout_err; c++) begin
      if (adc_hold) cnt++;
      check("tmo_no_valid", result_valid, 0);
      tick();
    end
    check("tmo_pulse", timeout_err, 1);
    check("tmo_cycles", cnt, TMO);
    check("tmo_ack", ack, 1 << ch);
    check("tmo_valid", result_valid, 0);
    check("tmo_data_kept", result_data, prev);
    req[ch] = 1'b0;
    tick();
    check("tmo_pulse_end", timeout_err, 0);
    check("tmo_idle", busy, 0);
`else
    // Without the watchdog a long conversion simply waits
    req = 4'b1000;
    conv(TMO + 16, 10'h1E1, 1'b0, 1'b0, 1'b1);
`endif

    // Asynchronous reset in the middle of CONVERT
    req = 4'b0100;
    ch = pick(req, rr);
    rr = (ch + 1) % N_CH;
    tick();
    cnt = 0;
    while (!adc_hold && cnt < S + 4) begin
      tick();
      cnt++;
    end
    check("pre_rst_hold", adc_hold, 1);
    tick();
    reset = 1'b0;
    #1;
    check("arst_hold", adc_hold, 0);
    check("arst_busy", busy, 0);
    check("arst_ch_sel", ch_sel, 0);
    check("arst_data", result_data, 0);
    check("arst_rch", result_ch, 0);
    check("arst_ack", ack, 0);
    check("arst_valid", result_valid, 0);
    check("arst_tmo", timeout_err, 0);
    #2 reset = 1'b1;
    rr = 0;
    req = 4'b1000;
    conv(4, 10'h3FF, 1'b0, 1'b0, 1'b1);
    check("after_rst_ch_sel", ch_sel, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
